// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor for beq.
// Predicts in ID from an untagged pattern table indexed by pc[IDX_BITS+1:2].
// Resolves in EX from the ALU Zero flag and trains the addressed entry.
// Optional feature macro: BRANCH_PERF_CNT_EN adds branch and mispredict
// event counters (branch_cnt_o, mispredict_cnt_o).
module branch_predictor #(
    parameter int         IDX_BITS   = 4,
    parameter logic [1:0] INIT_STATE = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    output logic        predict_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_pred_i,
    input  logic        ex_zero_i,
    output logic        flush_o,
    output logic        actual_taken_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
`endif
);

    localparam int DEPTH = 2 ** IDX_BITS;

    // Counter encoding: the MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    ctr_state_e          table_q [DEPTH];
    logic [IDX_BITS-1:0] id_idx;
    logic [IDX_BITS-1:0] ex_idx;
    ctr_state_e          ex_cur;
    ctr_state_e          ex_next;
    logic                update;
    logic                unused_pc_bits;

    // Only pc[IDX_BITS+1:2] selects an entry; word offset and upper bits alias.
    assign id_idx = id_pc_i[IDX_BITS+1:2];
    assign ex_idx = ex_pc_i[IDX_BITS+1:2];
    assign unused_pc_bits = ^{id_pc_i[31:IDX_BITS+2], id_pc_i[1:0],
                              ex_pc_i[31:IDX_BITS+2], ex_pc_i[1:0]};

    // A resolved branch trains the table only when the pipeline advances.
    assign update = ex_valid_i & ~stall_i;

    // Prediction reads the stored entry directly: a same-cycle write to the
    // same index is not bypassed, so the new value shows up one cycle later.
    assign predict_o = id_valid_i & table_q[id_idx][1];

    // Resolution is purely combinational and ignores stall.
    assign actual_taken_o = ex_valid_i & ex_zero_i;
    assign flush_o        = ex_valid_i & (ex_pred_i ^ ex_zero_i);

    assign ex_cur = table_q[ex_idx];

    // Next state of the entry addressed by the EX branch.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        ex_next = ex_cur;
        unique case (ex_cur)
            SNT: ex_next = ex_zero_i ? WNT : SNT;
            WNT: ex_next = ex_zero_i ? WT  : SNT;
            WT:  ex_next = ex_zero_i ? ST  : WNT;
            ST:  ex_next = ex_zero_i ? ST  : WT;
        endcase
    end

    // Pattern table: async reset to INIT_STATE, at most one entry stepped per edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: the table is a flop array, not a RAM, because reset must clear every entry at once.
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= ctr_state_e'(INIT_STATE);
            end
        end else if (update) begin
            // NOTE: non-blocking assignment so the read above sees the pre-edge value.
            table_q[ex_idx] <= ex_next;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    // Event counters for resolved branches and mispredictions; wrap at 2**32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (update) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (flush_o) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized checks of branch_predictor
// against a counter-array model that follows the saturating-counter rules.
module tb_branch_predictor;

    localparam int IDX_BITS = 4;
    localparam int DEPTH    = 16;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic        predict_o;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_pred_i;
    logic        ex_zero_i;
    logic        flush_o;
    logic        actual_taken_o;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;
`endif

    branch_predictor #(.IDX_BITS(IDX_BITS), .INIT_STATE(2'b11)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .id_valid_i     (id_valid_i),
        .id_pc_i        (id_pc_i),
        .predict_o      (predict_o),
        .ex_valid_i     (ex_valid_i),
        .ex_pc_i        (ex_pc_i),
        .ex_pred_i      (ex_pred_i),
        .ex_zero_i      (ex_zero_i),
        .flush_o        (flush_o),
        .actual_taken_o (actual_taken_o)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: each entry is a confidence count 0..3; taken when count >= 2.
    int          model_cnt [DEPTH];
    logic [31:0] model_branches;
    logic [31:0] model_mispredicts;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cleared on reset, one saturating step per unstalled resolved branch.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) model_cnt[i] <= 3;
            model_branches    <= 0;
            model_mispredicts <= 0;
        end else if (ex_valid_i && !stall_i) begin
            if (ex_zero_i) model_cnt[idx_of(ex_pc_i)] <= (model_cnt[idx_of(ex_pc_i)] == 3) ? 3 : model_cnt[idx_of(ex_pc_i)] + 1;
            else           model_cnt[idx_of(ex_pc_i)] <= (model_cnt[idx_of(ex_pc_i)] == 0) ? 0 : model_cnt[idx_of(ex_pc_i)] - 1;
            model_branches <= model_branches + 1;
            if (ex_pred_i != ex_zero_i) model_mispredicts <= model_mispredicts + 1;
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("cyc_predict", {31'd0, predict_o},
                  {31'd0, id_valid_i && (model_cnt[idx_of(id_pc_i)] >= 2)});
            check("cyc_flush", {31'd0, flush_o}, {31'd0, ex_valid_i && (ex_pred_i != ex_zero_i)});
            check("cyc_actual", {31'd0, actual_taken_o}, {31'd0, ex_valid_i && ex_zero_i});
`ifdef BRANCH_PERF_CNT_EN
            check("cyc_branch_cnt", branch_cnt_o, model_branches);
            check("cyc_mispredict_cnt", mispredict_cnt_o, model_mispredicts);
`endif
        end
    end

    task automatic drive(input logic idv, input logic [31:0] idpc, input logic exv,
                         input logic [31:0] expc, input logic pred, input logic zero,
                         input logic stall);
        id_valid_i = idv;
        id_pc_i    = idpc;
        ex_valid_i = exv;
        ex_pc_i    = expc;
        ex_pred_i  = pred;
        ex_zero_i  = zero;
        stall_i    = stall;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [31:0] r;

    initial begin
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        cmp_en = 1'b1;

        // Reset state: every entry strongly taken.
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        #1;
        check("reset_predict", {31'd0, predict_o}, 32'd1);
        check("reset_flush", {31'd0, flush_o}, 32'd0);
        check("reset_actual", {31'd0, actual_taken_o}, 32'd0);

        // Two not-taken resolutions at 0x10: ST -> WT -> WNT.
        drive(1, 32'h10, 1, 32'h10, 1, 0, 0);
        #1;
        check("nt_flush0", {31'd0, flush_o}, 32'd1);
        tick();
        check("nt1_predict", {31'd0, predict_o}, 32'd1);
        check("nt_flush1", {31'd0, flush_o}, 32'd1);
        tick();
        check("nt2_predict", {31'd0, predict_o}, 32'd0);

        // Saturate at SNT, then two taken: WNT (0), WT (1).
        repeat (3) tick();
        check("snt_predict", {31'd0, predict_o}, 32'd0);
        drive(1, 32'h10, 1, 32'h10, 0, 1, 0);
        tick();
        check("t1_predict", {31'd0, predict_o}, 32'd0);
        tick();
        check("t2_predict", {31'd0, predict_o}, 32'd1);

        // Same-edge read/write at 0x20 (entry at WT), no bypass.
        drive(0, 0, 1, 32'h20, 1, 0, 0);
        tick();
        drive(1, 32'h20, 1, 32'h20, 1, 0, 0);
        #1;
        check("same_edge_pre", {31'd0, predict_o}, 32'd1);
        tick();
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        #1;
        check("same_edge_post", {31'd0, predict_o}, 32'd0);
        drive(1, 32'h60, 0, 0, 0, 0, 0);
        #1;
        check("alias_read", {31'd0, predict_o}, 32'd0);
        drive(0, 0, 1, 32'h60, 0, 1, 0);
        tick();
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        #1;
        check("alias_train", {31'd0, predict_o}, 32'd1);

        // Stall: entry at WNT, taken resolution held for three edges.
        drive(1, 32'h20, 1, 32'h20, 1, 0, 0);
        tick();
        drive(1, 32'h20, 1, 32'h20, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_flush", {31'd0, flush_o}, 32'd1);
            check("stall_actual", {31'd0, actual_taken_o}, 32'd1);
            check("stall_predict", {31'd0, predict_o}, 32'd0);
            tick();
        end
        drive(1, 32'h20, 1, 32'h20, 0, 1, 0);
        tick();
        drive(1, 32'h20, 0, 0, 0, 0, 0);
        #1;
        check("unstall_step", {31'd0, predict_o}, 32'd1);
        drive(1, 32'h20, 1, 32'h20, 1, 0, 0);
        tick();
        check("unstall_single", {31'd0, predict_o}, 32'd0);

        // Fresh reset, then five resolved branches at 0x10, two mispredicted.
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst_i = 1'b0;
        #1 rst_i = 1'b1;
        drive(0, 0, 1, 32'h10, 1, 0, 0); tick();
        drive(0, 0, 1, 32'h10, 0, 0, 0); tick();
        drive(0, 0, 1, 32'h10, 1, 1, 0); tick();
        drive(0, 0, 1, 32'h10, 1, 0, 0); tick();
        drive(0, 0, 1, 32'h10, 0, 0, 0); tick();
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        #1;
        check("five_predict", {31'd0, predict_o}, 32'd0);
`ifdef BRANCH_PERF_CNT_EN
        check("branch_cnt5", branch_cnt_o, 32'd5);
        check("mispredict_cnt2", mispredict_cnt_o, 32'd2);
`endif

        // Mid-cycle async reset; held across edges with a pending update.
        drive(1, 32'h10, 1, 32'h10, 1, 0, 0);
        #1 rst_i = 1'b0;
        #1;
        check("async_rst_predict", {31'd0, predict_o}, 32'd1);
`ifdef BRANCH_PERF_CNT_EN
        check("async_rst_branch_cnt", branch_cnt_o, 32'd0);
        check("async_rst_mispredict_cnt", mispredict_cnt_o, 32'd0);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            drive(1, {r[31:6], i[3:0], r[1:0]}, 1, 32'h10, 1, 0, 0);
            #3;
            check("rst_all_st", {31'd0, predict_o}, 32'd1);
        end
        tick();
        rst_i = 1'b1;
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        #1;
        check("no_update_in_rst", {31'd0, predict_o}, 32'd1);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 2000; n++) begin
            tick();
            r = $urandom;
            id_valid_i = r[0];
            id_pc_i    = $urandom;
            ex_valid_i = (r[3:1] != 3'd0);
            ex_pc_i    = r[4] ? {$urandom_range(0, 255), 8'd0} | (id_pc_i & 32'h3C) : $urandom;
            ex_pred_i  = r[5];
            ex_zero_i  = r[6];
            stall_i    = (r[8:7] == 2'd0);
            if (r[17:10] == 8'd0) begin
                #1 rst_i = 1'b0;
                #1 rst_i = 1'b1;
            end
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
